// File: rtl/card_sprite_render.sv
// card_sprite_render: overlays a 16x32 card sprite, read from an external sync RAM, onto the VGA pixel stream.
// Ports: clock/reset, scan position + background in, double-buffered card position in, RAM read port, pixel out.
// Latency 3 clocks, 1 pixel/clock, no backpressure. Optional `CARD_MIRROR_EN adds mirror_i for horizontal flip.
module card_sprite_render #(
  parameter int                 CARD_W     = 16,
  parameter int                 CARD_H     = 32,
  parameter int                 ADDR_W     = 9,
  parameter int                 COLOR_W    = 3,
  parameter logic [COLOR_W-1:0] TRANSP_CLR = '0
) (
  input  logic               clock_i,
  input  logic               reset_n_i,
  input  logic               frame_start_i,
  input  logic               pixel_valid_i,
  input  logic [7:0]         pixel_x_i,
  input  logic [7:0]         pixel_y_i,
  input  logic [COLOR_W-1:0] bg_color_i,
  input  logic               pos_load_i,
  input  logic [7:0]         pos_x_i,
  input  logic [7:0]         pos_y_i,
  input  logic               show_i,
`ifdef CARD_MIRROR_EN
  input  logic               mirror_i,
`endif
  output logic               pos_pending_o,
  output logic               mem_re_o,
  output logic [ADDR_W-1:0]  mem_raddr_o,
  input  logic [COLOR_W-1:0] mem_rdata_i,
  output logic               pix_valid_o,
  output logic [COLOR_W-1:0] pix_color_o,
  output logic               card_hit_o
);

  localparam int COL_W = $clog2(CARD_W);
  localparam int ROW_W = ADDR_W - COL_W;
  localparam logic [8:0]       CARD_W9 = 9'(CARD_W);
  localparam logic [8:0]       CARD_H9 = 9'(CARD_H);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(CARD_W - 1);

  typedef enum logic {IDLE, PENDING} pos_state_e;

  pos_state_e         state_q;
  logic [7:0]         shd_x_q, shd_y_q, act_x_q, act_y_q;
  logic               shd_show_q, act_show_q;

  logic               s1_vld_q, s1_hit_q, s2_vld_q, s2_hit_q;
  logic [COLOR_W-1:0] s1_bg_q, s2_bg_q;
  logic               mem_re_q, pix_valid_q, card_hit_q;
  logic [ADDR_W-1:0]  mem_raddr_q;
  logic [COLOR_W-1:0] pix_color_q;

  // Stage 0: hit test against the active (frame-stable) position.
  // 9-bit differences keep the subtraction from wrapping, so a card near
  // the right/bottom edge is clipped rather than reappearing on the left/top.
  logic [8:0]        dx, dy;
  logic              hit_d;
  logic [COL_W-1:0]  col_d;
  logic [ADDR_W-1:0] raddr_d;

  assign dx = {1'b0, pixel_x_i} - {1'b0, act_x_q};
  assign dy = {1'b0, pixel_y_i} - {1'b0, act_y_q};

  assign hit_d = act_show_q & pixel_valid_i
               & (pixel_x_i >= act_x_q) & (dx < CARD_W9)
               & (pixel_y_i >= act_y_q) & (dy < CARD_H9);

`ifdef CARD_MIRROR_EN
  assign col_d = mirror_i ? (COL_MAX - dx[COL_W-1:0]) : dx[COL_W-1:0];
`else
  assign col_d = dx[COL_W-1:0];
`endif

  assign raddr_d = {dy[ROW_W-1:0], col_d};

  // Position double-buffer. A load coinciding with frame start bypasses
  // the shadow so the new position is live for the very next frame.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= IDLE;
      shd_x_q    <= '0;
      shd_y_q    <= '0;
      shd_show_q <= 1'b0;
      act_x_q    <= '0;
      act_y_q    <= '0;
      act_show_q <= 1'b0;
    end else begin
      if (pos_load_i && frame_start_i) begin
        act_x_q    <= pos_x_i;
        act_y_q    <= pos_y_i;
        act_show_q <= show_i;
        state_q    <= IDLE;
      end else if (pos_load_i) begin
        shd_x_q    <= pos_x_i;
        shd_y_q    <= pos_y_i;
        shd_show_q <= show_i;
        state_q    <= PENDING;
      end else if (frame_start_i && state_q == PENDING) begin
        act_x_q    <= shd_x_q;
        act_y_q    <= shd_y_q;
        act_show_q <= shd_show_q;
        state_q    <= IDLE;
      end
    end
  end

  assign pos_pending_o = (state_q == PENDING);

  // Stages 1..3. The RAM samples mem_raddr at the end of stage 1, so its
  // data lines up with the stage-2 registers and is merged into stage 3.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      s1_vld_q    <= 1'b0;
      s1_hit_q    <= 1'b0;
      s1_bg_q     <= '0;
      mem_re_q    <= 1'b0;
      mem_raddr_q <= '0;
      s2_vld_q    <= 1'b0;
      s2_hit_q    <= 1'b0;
      s2_bg_q     <= '0;
      pix_valid_q <= 1'b0;
      pix_color_q <= '0;
      card_hit_q  <= 1'b0;
    end else begin
      s1_vld_q <= pixel_valid_i;
      s1_hit_q <= hit_d;
      s1_bg_q  <= bg_color_i;
      mem_re_q <= hit_d;
      if (hit_d) mem_raddr_q <= raddr_d;

      s2_vld_q <= s1_vld_q;
      s2_hit_q <= s1_hit_q;
      s2_bg_q  <= s1_bg_q;

      pix_valid_q <= s2_vld_q;
      if (!s2_vld_q) begin
        pix_color_q <= '0;
        card_hit_q  <= 1'b0;
      end else if (s2_hit_q && mem_rdata_i != TRANSP_CLR) begin
        pix_color_q <= mem_rdata_i;
        card_hit_q  <= 1'b1;
      end else begin
        pix_color_q <= s2_bg_q;
        card_hit_q  <= 1'b0;
      end
    end
  end

  assign mem_re_o    = mem_re_q;
  assign mem_raddr_o = mem_raddr_q;
  assign pix_valid_o = pix_valid_q;
  assign pix_color_o = pix_color_q;
  assign card_hit_o  = card_hit_q;

endmodule

// File: tb/tb_card_sprite_render.sv
// Testbench for card_sprite_render: directed pixels, expected results queued by the driver,
// compared by independent monitors on the RAM read port and the pixel output.
// Sync-read RAM model inside the bench; all checks sampled on the falling clock edge.
module tb_card_sprite_render;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_start = 1'b0, pixel_valid = 1'b0, pos_load = 1'b0, show = 1'b0;
  logic [7:0] pixel_x = '0, pixel_y = '0, pos_x = '0, pos_y = '0;
  logic [2:0] bg_color = '0;
  logic       mirror_v = 1'b0;
  logic       pos_pending, mem_re, pix_valid, card_hit;
  logic [8:0] mem_raddr;
  logic [2:0] mem_rdata = '0, pix_color;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [2:0] ram [512];

  typedef struct { logic [2:0] color; logic hit; int cyc; } pexp_t;
  typedef struct { int addr; int cyc; } aexp_t;
  pexp_t pq[$];
  aexp_t aq[$];

  card_sprite_render dut (
    .clock_i      (clk),
    .reset_n_i    (rst_n),
    .frame_start_i(frame_start),
    .pixel_valid_i(pixel_valid),
    .pixel_x_i    (pixel_x),
    .pixel_y_i    (pixel_y),
    .bg_color_i   (bg_color),
    .pos_load_i   (pos_load),
    .pos_x_i      (pos_x),
    .pos_y_i      (pos_y),
    .show_i       (show),
`ifdef CARD_MIRROR_EN
    .mirror_i     (mirror_v),
`endif
    .pos_pending_o(pos_pending),
    .mem_re_o     (mem_re),
    .mem_raddr_o  (mem_raddr),
    .mem_rdata_i  (mem_rdata),
    .pix_valid_o  (pix_valid),
    .pix_color_o  (pix_color),
    .card_hit_o   (card_hit)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_re) mem_rdata <= ram[mem_raddr];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: one for the RAM read port, one for the pixel output.
  always @(negedge clk) begin
    if (rst_n && mem_re) begin
      if (aq.size() == 0) begin
        total++; bad++;
        $display("FAIL mem_re_unexpected: got mem_re=1 addr=%0d expected no read (cycle %0d)", mem_raddr, cyc);
      end else begin
        aexp_t a;
        a = aq.pop_front();
        chk("mem_raddr", int'(mem_raddr), a.addr);
        chk("mem_re_cycle", cyc, a.cyc);
      end
    end
    if (rst_n && pix_valid) begin
      if (pq.size() == 0) begin
        total++; bad++;
        $display("FAIL pix_unexpected: got pix_valid=1 color=%0d expected no pixel (cycle %0d)", pix_color, cyc);
      end else begin
        pexp_t p;
        p = pq.pop_front();
        chk("pix_color", int'(pix_color), int'(p.color));
        chk("card_hit", int'(card_hit), int'(p.hit));
        chk("pix_latency", cyc, p.cyc);
      end
    end
  end

  // One clock of stimulus; eh/ea are the hand-derived hit flag and RAM address.
  task automatic step(input logic pv, input logic [7:0] x, input logic [7:0] y, input logic [2:0] bg,
                      input logic fs, input logic pl, input logic [7:0] px, input logic [7:0] py,
                      input logic sh, input logic eh, input int ea);
    pexp_t p;
    aexp_t a;
    @(negedge clk);
    pixel_valid = pv; pixel_x = x; pixel_y = y; bg_color = bg;
    frame_start = fs; pos_load = pl; pos_x = px; pos_y = py; show = sh;
    if (pv) begin
      p.hit   = eh && (ram[ea] != 3'b000);
      p.color = p.hit ? ram[ea] : bg;
      p.cyc   = cyc + 3;
      pq.push_back(p);
    end
    if (eh) begin
      a.addr = ea;
      a.cyc  = cyc + 1;
      aq.push_back(a);
    end
  endtask

  task automatic pix(input logic [7:0] x, input logic [7:0] y, input logic [2:0] bg,
                     input logic eh, input int ea);
    step(1'b1, x, y, bg, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, eh, ea);
  endtask

  task automatic idle();
    step(1'b0, 8'd0, 8'd0, 3'b000, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 0);
  endtask

  task automatic load(input logic [7:0] px, input logic [7:0] py, input logic sh, input logic fs);
    step(1'b0, 8'd0, 8'd0, 3'b000, fs, 1'b1, px, py, sh, 1'b0, 0);
  endtask

  task automatic fstart();
    step(1'b0, 8'd0, 8'd0, 3'b000, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pix_valid"}, int'(pix_valid), 0);
    chk({tag, "_pix_color"}, int'(pix_color), 0);
    chk({tag, "_card_hit"}, int'(card_hit), 0);
    chk({tag, "_mem_re"}, int'(mem_re), 0);
    chk({tag, "_mem_raddr"}, int'(mem_raddr), 0);
    chk({tag, "_pos_pending"}, int'(pos_pending), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 512; i++) ram[i] = 3'((i % 7) + 1);
    ram[5] = 3'b000;  // transparent texel

    // Reset state
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Card hidden after reset: everything is background
    idle();
    pix(8'd0, 8'd0, 3'b011, 1'b0, 0);
    pix(8'd40, 8'd20, 3'b110, 1'b0, 0);

    // Load mid-frame goes pending, applied at frame start
    load(8'd40, 8'd20, 1'b1, 1'b0);
    idle();
    chk("pending_after_load", int'(pos_pending), 1);
    fstart();
    idle();
    chk("pending_after_fs", int'(pos_pending), 0);

    pix(8'd40, 8'd20, 3'b001, 1'b1, 0);
    pix(8'd55, 8'd51, 3'b001, 1'b1, 511);
    pix(8'd47, 8'd25, 3'b110, 1'b1, 87);
    pix(8'd56, 8'd20, 3'b100, 1'b0, 0);
    pix(8'd39, 8'd20, 3'b100, 1'b0, 0);
    pix(8'd40, 8'd52, 3'b111, 1'b0, 0);
    pix(8'd40, 8'd19, 3'b111, 1'b0, 0);
    pix(8'd45, 8'd20, 3'b101, 1'b1, 5);  // transparent texel -> background
    // pixel_valid low inside the card: no read, no output
    step(1'b0, 8'd40, 8'd20, 3'b001, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 0);

    // Load together with frame start: applied at once, never pending
    load(8'd250, 8'd100, 1'b1, 1'b1);
    idle();
    chk("pending_load_fs_same", int'(pos_pending), 0);
    pix(8'd255, 8'd101, 3'b010, 1'b1, 21);
    pix(8'd0, 8'd101, 3'b010, 1'b0, 0);    // no horizontal wrap
    pix(8'd249, 8'd101, 3'b010, 1'b0, 0);
    pix(8'd250, 8'd115, 3'b011, 1'b1, 240);

    // Two loads mid-frame: old position keeps rendering, last load wins
    load(8'd100, 8'd100, 1'b1, 1'b0);
    load(8'd10, 8'd230, 1'b1, 1'b0);
    idle();
    chk("pending_two_loads", int'(pos_pending), 1);
    pix(8'd255, 8'd101, 3'b010, 1'b1, 21);
    pix(8'd10, 8'd230, 3'b100, 1'b0, 0);
    // Pixel in the frame-start cycle still uses the old position
    step(1'b1, 8'd10, 8'd230, 3'b100, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 0);
    idle();
    chk("pending_cleared", int'(pos_pending), 0);
    pix(8'd10, 8'd230, 3'b100, 1'b1, 0);
    pix(8'd25, 8'd239, 3'b100, 1'b1, 159);  // bottom row of clipped card
    pix(8'd10, 8'd229, 3'b100, 1'b0, 0);
    pix(8'd100, 8'd100, 3'b100, 1'b0, 0);
    pix(8'd255, 8'd101, 3'b100, 1'b0, 0);

    // show=0 hides the card
    load(8'd10, 8'd230, 1'b0, 1'b1);
    pix(8'd10, 8'd230, 3'b001, 1'b0, 0);

`ifdef CARD_MIRROR_EN
    load(8'd40, 8'd20, 1'b1, 1'b1);
    mirror_v = 1'b1;
    pix(8'd40, 8'd20, 3'b001, 1'b1, 15);
    pix(8'd55, 8'd21, 3'b001, 1'b1, 16);
    mirror_v = 1'b0;
    pix(8'd40, 8'd20, 3'b001, 1'b1, 0);
`endif

    // Reset with pixels in flight
    load(8'd40, 8'd20, 1'b1, 1'b1);
    pix(8'd40, 8'd20, 3'b001, 1'b1, 0);
    pix(8'd41, 8'd20, 3'b001, 1'b1, 1);
    pix(8'd42, 8'd20, 3'b001, 1'b1, 2);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    pixel_valid = 1'b0;
    #1;
    chk_all_zero("midrst");
    pq.delete();
    aq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle();
    idle();
    idle();
    pix(8'd40, 8'd20, 3'b010, 1'b0, 0);  // position reset to hidden
    pix(8'd0, 8'd0, 3'b111, 1'b0, 0);

    repeat (6) idle();
    chk("pix_queue_drained", pq.size(), 0);
    chk("addr_queue_drained", aq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
